// File: rtl/position_overlay.sv
// Draws a square marker outline around a per-frame centroid and holds it through short dropouts.
// The marker is sampled once per frame, one cycle after the raster reaches the frame-end position.
module position_overlay #(
    parameter int INPUT_WIDTH = 11,
    parameter int COLOR_WIDTH = 10,
    parameter int FRAME_X_MAX = 640,
    parameter int FRAME_Y_MAX = 480,
    parameter int BOX_HALF    = 8,
    parameter int HOLD_FRAMES = 4,
    parameter logic [3*COLOR_WIDTH-1:0] MARKER_COLOR = {10'h3FF, 10'h000, 10'h000}
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [INPUT_WIDTH-1:0]   vga_x,
    input  logic [INPUT_WIDTH-1:0]   vga_y,
    input  logic [3*COLOR_WIDTH-1:0] pixel_in,
    input  logic [INPUT_WIDTH-1:0]   x_position,
    input  logic [INPUT_WIDTH-1:0]   y_position,
    output logic [3*COLOR_WIDTH-1:0] pixel_out,
    output logic [INPUT_WIDTH-1:0]   marker_x,
    output logic [INPUT_WIDTH-1:0]   marker_y,
    output logic                     marker_valid,
    output logic                     coasting
);
    localparam int CNT_W = $clog2(HOLD_FRAMES + 1);
    localparam logic [INPUT_WIDTH-1:0] FRAME_X  = FRAME_X_MAX[INPUT_WIDTH-1:0];
    localparam logic [INPUT_WIDTH-1:0] FRAME_Y  = FRAME_Y_MAX[INPUT_WIDTH-1:0];
    localparam logic [CNT_W-1:0]       HOLD_CNT = HOLD_FRAMES[CNT_W-1:0];
    localparam logic [INPUT_WIDTH:0]   BOX_H    = BOX_HALF[INPUT_WIDTH:0];

    typedef enum logic [1:0] {IDLE, TRACK, COAST} state_t;

    state_t                     state_q;
    logic [CNT_W-1:0]           miss_cnt_q;
    logic [INPUT_WIDTH-1:0]     marker_x_q, marker_y_q;
    logic                       marker_valid_q, coasting_q;
    logic                       frame_end_q;
    logic [3*COLOR_WIDTH-1:0]   pixel_q, pixel_d;

    logic frame_end, sample_pulse, sample_miss;
    assign frame_end    = enable && (vga_x == FRAME_X) && (vga_y == FRAME_Y);
    assign sample_pulse = enable && frame_end_q;
    assign sample_miss  = (&x_position) && (&y_position);

    always_ff @(posedge clk) begin
        if (reset) frame_end_q <= 1'b0;
        else       frame_end_q <= frame_end;
    end

    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            state_q        <= IDLE;
            miss_cnt_q     <= '0;
            marker_x_q     <= '0;
            marker_y_q     <= '0;
            marker_valid_q <= 1'b0;
            coasting_q     <= 1'b0;
        end else if (sample_pulse) begin
            if (!sample_miss) begin
                state_q        <= TRACK;
                miss_cnt_q     <= '0;
                marker_x_q     <= x_position;
                marker_y_q     <= y_position;
                marker_valid_q <= 1'b1;
                coasting_q     <= 1'b0;
            end else begin
                case (state_q)
                    TRACK: begin
                        state_q        <= COAST;
                        miss_cnt_q     <= CNT_W'(1);
                        marker_valid_q <= 1'b1;
                        coasting_q     <= 1'b1;
                    end
                    COAST: begin
                        // Saturating compare keeps the counter from ever wrapping.
                        if (miss_cnt_q >= HOLD_CNT) begin
                            state_q        <= IDLE;
                            miss_cnt_q     <= '0;
                            marker_valid_q <= 1'b0;
                            coasting_q     <= 1'b0;
                        end else begin
                            miss_cnt_q <= miss_cnt_q + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_q        <= IDLE;
                        marker_valid_q <= 1'b0;
                        coasting_q     <= 1'b0;
                    end
                endcase
            end
        end
    end

    // One extra bit on the differences so markers near x=0 never alias to the far edge.
    logic signed [INPUT_WIDTH:0] dx, dy;
    logic        [INPUT_WIDTH:0] adx, ady;
    logic                        on_outline;
    assign dx  = $signed({1'b0, vga_x}) - $signed({1'b0, marker_x_q});
    assign dy  = $signed({1'b0, vga_y}) - $signed({1'b0, marker_y_q});
    assign adx = dx[INPUT_WIDTH] ? $unsigned(-dx) : $unsigned(dx);
    assign ady = dy[INPUT_WIDTH] ? $unsigned(-dy) : $unsigned(dy);
    assign on_outline = (adx <= BOX_H) && (ady <= BOX_H) && ((adx == BOX_H) || (ady == BOX_H));

    assign pixel_d = (enable && marker_valid_q && on_outline) ? MARKER_COLOR : pixel_in;

    always_ff @(posedge clk) begin
        if (reset) pixel_q <= '0;
        else       pixel_q <= pixel_d;
    end

    assign pixel_out    = pixel_q;
    assign marker_x     = marker_x_q;
    assign marker_y     = marker_y_q;
    assign marker_valid = marker_valid_q;
    assign coasting     = coasting_q;
endmodule
